// File: rtl/picorv32_mem_arbiter_if.sv
// Valid/ready word-access port as issued by the PicoRV32 native memory interface.
// The requester drives valid/addr/wdata/wstrb; the arbiter answers with a one-cycle ready pulse and rdata.
interface picorv32_mem_arbiter_if;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/picorv32_mem_arbiter.sv
// Round-robin arbiter sharing one single-port, one-cycle-latency SRAM between two PicoRV32-style masters.
// Valid sampled in IDLE -> mem_en next cycle -> ready the cycle after; one access per 3 cycles, masters hold valid until ready.
module picorv32_mem_arbiter #(
  parameter int ADDR_W = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  picorv32_mem_arbiter_if.slave m0,
  picorv32_mem_arbiter_if.slave m1,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  oor_err,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t            state;
  logic              last_grant;
  logic              req_grant;
  logic              req_oor;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_wstrb;

  logic              sel;
  logic [31:0]       sel_addr;
  logic [31:0]       sel_wdata;
  logic [3:0]        sel_wstrb;
  logic              sel_oor;
  logic [31:0]       done_rdata;
  logic              unused_addr_lsb;

  // On a tie the master not served last wins; a lone requester always wins.
  assign sel       = (m0.valid && m1.valid) ? ~last_grant : m1.valid;
  assign sel_addr  = sel ? m1.addr  : m0.addr;
  assign sel_wdata = sel ? m1.wdata : m0.wdata;
  assign sel_wstrb = sel ? m1.wstrb : m0.wstrb;
  assign sel_oor   = |sel_addr[31:ADDR_W+2];
  assign unused_addr_lsb = ^sel_addr[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      req_grant  <= 1'b0;
      req_oor    <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
      req_wstrb  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (m0.valid || m1.valid) begin
            req_grant <= sel;
            req_addr  <= sel_addr[ADDR_W+1:2];
            req_wdata <= sel_wdata;
            req_wstrb <= sel_wstrb;
            req_oor   <= sel_oor;
            state     <= S_ACCESS;
          end
        end
        S_ACCESS: state <= S_DONE;
        S_DONE: begin
          last_grant <= req_grant;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Reset gates the SRAM strobe combinationally so an interrupted write never commits.
  assign done_rdata = req_oor ? 32'h0 : mem_rdata;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    m0.ready  = 1'b0;
    m0.rdata  = 32'h0;
    m1.ready  = 1'b0;
    m1.rdata  = 32'h0;
    oor_err   = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_ACCESS: begin
        mem_en    = !req_oor && !reset;
        mem_we    = (!req_oor && !reset) ? req_wstrb : 4'b0000;
        mem_addr  = req_addr;
        mem_wdata = req_wdata;
      end
      S_DONE: begin
        oor_err = req_oor;
        if (req_grant) begin
          m1.ready = 1'b1;
          m1.rdata = done_rdata;
        end else begin
          m0.ready = 1'b1;
          m0.rdata = done_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Directed bench for picorv32_mem_arbiter with a read-first one-cycle SRAM model.
module tb_picorv32_mem_arbiter;
  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              reset;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              oor_err;
  logic              busy;

  logic              pre_en;
  logic [ADDR_W-1:0] pre_addr;
  logic [31:0]       pre_data;
  logic [31:0]       sram [0:(1<<ADDR_W)-1];

  int n_checks = 0;
  int n_fail   = 0;

  picorv32_mem_arbiter_if m0_bus ();
  picorv32_mem_arbiter_if m1_bus ();

  picorv32_mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0        (m0_bus),
    .m1        (m1_bus),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .oor_err   (oor_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_en) begin
      sram[pre_addr] <= pre_data;
    end else if (mem_en) begin
      mem_rdata <= sram[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "timeout");
  end

  task automatic drive(input int m, input logic v, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    if (m == 0) begin
      m0_bus.valid = v; m0_bus.addr = a; m0_bus.wdata = d; m0_bus.wstrb = s;
    end else begin
      m1_bus.valid = v; m1_bus.addr = a; m1_bus.wdata = d; m1_bus.wstrb = s;
    end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_data = 32'h0;
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk); @(negedge clk);
    n_checks++; if ({m0_bus.ready, m1_bus.ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", {m0_bus.ready, m1_bus.ready}); end
    n_checks++; if ({m0_bus.rdata, m1_bus.rdata} !== 64'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", {m0_bus.rdata, m1_bus.rdata}); end
    n_checks++; if ({mem_en, mem_we} !== 5'b0) begin n_fail++; $display("FAIL reset_mem_en_we: got %b expected 0", {mem_en, mem_we}); end
    n_checks++; if ({mem_addr, mem_wdata} !== '0) begin n_fail++; $display("FAIL reset_mem_addr_wdata: got %h expected 0", {mem_addr, mem_wdata}); end
    n_checks++; if ({oor_err, busy} !== 2'b00) begin n_fail++; $display("FAIL reset_oor_busy: got %b expected 00", {oor_err, busy}); end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    preload(14'h10, 32'hDEADBEEF);
    preload(14'h11, 32'h11223344);
    drive(0, 1'b1, 32'h40, 32'h0, 4'h0);
    @(negedge clk);
    n_checks++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL read_mem_en: got %b expected 1", mem_en); end
    n_checks++; if (mem_addr !== 14'h10) begin n_fail++; $display("FAIL read_mem_addr: got %h expected 010", mem_addr); end
    n_checks++; if ({mem_we, busy, m0_bus.ready} !== 6'b0000_1_0) begin n_fail++; $display("FAIL read_access_ctl: got %b expected 000010", {mem_we, busy, m0_bus.ready}); end
    @(negedge clk);
    n_checks++; if ({m0_bus.ready, m1_bus.ready, mem_en} !== 3'b100) begin n_fail++; $display("FAIL read_ready: got %b expected 100", {m0_bus.ready, m1_bus.ready, mem_en}); end
    n_checks++; if (m0_bus.rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_rdata: got %h expected deadbeef", m0_bus.rdata); end
    n_checks++; if ({m1_bus.rdata, oor_err} !== 33'h0) begin n_fail++; $display("FAIL read_other_master: got %h expected 0", {m1_bus.rdata, oor_err}); end
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL read_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_byte_write();
    drive(1, 1'b1, 32'h44, 32'hAABBCCDD, 4'b0100);
    @(negedge clk);
    n_checks++; if ({mem_en, mem_we} !== 5'b1_0100) begin n_fail++; $display("FAIL bytewr_we: got %b expected 10100", {mem_en, mem_we}); end
    n_checks++; if ({mem_addr, mem_wdata} !== {14'h11, 32'hAABBCCDD}) begin n_fail++; $display("FAIL bytewr_addr_data: got %h/%h expected 011/aabbccdd", mem_addr, mem_wdata); end
    @(negedge clk);
    n_checks++; if ({m1_bus.ready, m0_bus.ready} !== 2'b10) begin n_fail++; $display("FAIL bytewr_ready: got %b expected 10", {m1_bus.ready, m0_bus.ready}); end
    n_checks++; if (m1_bus.rdata !== 32'h11223344) begin n_fail++; $display("FAIL bytewr_rdata: got %h expected 11223344", m1_bus.rdata); end
    drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    drive(0, 1'b1, 32'h44, 32'h0, 4'h0);
    @(negedge clk); @(negedge clk);
    n_checks++; if ({m0_bus.ready, m0_bus.rdata} !== {1'b1, 32'h11BB3344}) begin n_fail++; $display("FAIL bytewr_readback: got %b/%h expected 1/11bb3344", m0_bus.ready, m0_bus.rdata); end
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_rdy;
    logic [5:0] exp_busy;
    exp_rdy  = 6'b010010;
    exp_busy = 6'b011011;
    drive(0, 1'b1, 32'h40, 32'h0, 4'h0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      n_checks++; if ({m0_bus.ready, busy} !== {exp_rdy[i-1], exp_busy[i-1]}) begin n_fail++; $display("FAIL b2b_cycle%0d: got ready/busy %b expected %b", i, {m0_bus.ready, busy}, {exp_rdy[i-1], exp_busy[i-1]}); end
      if (i == 5) drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    end
  endtask

  task automatic test_contention();
    int n_grant = 0;
    int n_double = 0;
    int last0 = -1;
    int last1 = -1;
    apply_reset();
    drive(0, 1'b1, 32'h40, 32'h0, 4'h0);
    drive(1, 1'b1, 32'h40, 32'h0, 4'h0);
    for (int i = 1; i <= 47; i++) begin
      @(negedge clk);
      if (m0_bus.ready && m1_bus.ready) n_double++;
      if (m0_bus.ready || m1_bus.ready) begin
        n_checks++; if (m1_bus.ready !== n_grant[0]) begin n_fail++; $display("FAIL contention_order%0d: got m1_ready %b expected %b", n_grant, m1_bus.ready, n_grant[0]); end
        if (m0_bus.ready) begin
          if (last0 >= 0) begin
            n_checks++; if (i - last0 != 6) begin n_fail++; $display("FAIL contention_m0_spacing: got %0d expected 6", i - last0); end
          end
          last0 = i;
        end else begin
          if (last1 >= 0) begin
            n_checks++; if (i - last1 != 6) begin n_fail++; $display("FAIL contention_m1_spacing: got %0d expected 6", i - last1); end
          end
          last1 = i;
        end
        n_grant++;
      end
      if (i == 47) begin
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
      end
    end
    n_checks++; if (n_grant != 16) begin n_fail++; $display("FAIL contention_grants: got %0d expected 16", n_grant); end
    n_checks++; if (n_double != 0) begin n_fail++; $display("FAIL contention_double: got %0d expected 0", n_double); end
    @(negedge clk);
  endtask

  task automatic test_oor();
    preload(14'h0, 32'hCAFEF00D);
    drive(0, 1'b1, 32'h0001_0000, 32'h12345678, 4'hF);
    @(negedge clk);
    n_checks++; if ({mem_en, mem_we, busy} !== 6'b0_0000_1) begin n_fail++; $display("FAIL oor_wr_access: got %b expected 000001", {mem_en, mem_we, busy}); end
    @(negedge clk);
    n_checks++; if ({m0_bus.ready, oor_err, m0_bus.rdata} !== {2'b11, 32'h0}) begin n_fail++; $display("FAIL oor_wr_done: got %b%b/%h expected 11/0", m0_bus.ready, oor_err, m0_bus.rdata); end
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    n_checks++; if (sram[0] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL oor_mem_unchanged: got %h expected cafef00d", sram[0]); end
    drive(0, 1'b1, 32'h0001_0000, 32'h0, 4'h0);
    @(negedge clk);
    n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL oor_rd_mem_en: got %b expected 0", mem_en); end
    @(negedge clk);
    n_checks++; if ({m0_bus.ready, oor_err, m0_bus.rdata} !== {2'b11, 32'h0}) begin n_fail++; $display("FAIL oor_rd_done: got %b%b/%h expected 11/0", m0_bus.ready, oor_err, m0_bus.rdata); end
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
  endtask

  task automatic test_reset_during_write();
    preload(14'h20, 32'h55555555);
    // m0 served last, so without a reset m1 would win the next tie.
    drive(0, 1'b1, 32'h40, 32'h0, 4'h0);
    @(negedge clk); @(negedge clk);
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    drive(1, 1'b1, 32'h80, 32'hFFFFFFFF, 4'hF);
    @(negedge clk);
    reset = 1'b1;
    drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    n_checks++; if ({mem_en, mem_we} !== 5'b0) begin n_fail++; $display("FAIL rstwr_gated: got %b expected 00000", {mem_en, mem_we}); end
    @(negedge clk);
    n_checks++; if ({m0_bus.ready, m1_bus.ready, mem_en, mem_we, oor_err, busy} !== 9'b0) begin n_fail++; $display("FAIL rstwr_ctl: got %b expected 0", {m0_bus.ready, m1_bus.ready, mem_en, mem_we, oor_err, busy}); end
    n_checks++; if ({m0_bus.rdata, m1_bus.rdata, mem_addr, mem_wdata} !== '0) begin n_fail++; $display("FAIL rstwr_data: got nonzero %h expected 0", {m0_bus.rdata, m1_bus.rdata, mem_addr, mem_wdata}); end
    n_checks++; if (sram[14'h20] !== 32'h55555555) begin n_fail++; $display("FAIL rstwr_mem: got %h expected 55555555", sram[14'h20]); end
    reset = 1'b0;
    drive(0, 1'b1, 32'h40, 32'h0, 4'h0);
    drive(1, 1'b1, 32'h40, 32'h0, 4'h0);
    @(negedge clk); @(negedge clk);
    n_checks++; if ({m0_bus.ready, m1_bus.ready} !== 2'b10) begin n_fail++; $display("FAIL rstwr_tie: got %b expected 10", {m0_bus.ready, m1_bus.ready}); end
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
  endtask

  task automatic test_dropped_valid();
    preload(14'h21, 32'h0);
    drive(1, 1'b1, 32'h84, 32'h0BADF00D, 4'hF);
    @(negedge clk);
    drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
    n_checks++; if ({mem_en, mem_we} !== 5'b1_1111) begin n_fail++; $display("FAIL drop_access: got %b expected 11111", {mem_en, mem_we}); end
    @(negedge clk);
    n_checks++; if ({m1_bus.ready, m0_bus.ready} !== 2'b10) begin n_fail++; $display("FAIL drop_ready: got %b expected 10", {m1_bus.ready, m0_bus.ready}); end
    @(negedge clk);
    n_checks++; if (sram[14'h21] !== 32'h0BADF00D) begin n_fail++; $display("FAIL drop_committed: got %h expected 0badf00d", sram[14'h21]); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle: got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_byte_write();
    test_back_to_back();
    test_contention();
    test_oor();
    test_reset_during_write();
    test_dropped_valid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/picorv32_mem_arbiter.md
# picorv32_mem_arbiter

Two-master arbiter that shares one single-port, one-cycle-latency word SRAM between the PicoRV32 native memory interface (master 0) and a second requester such as a program loader or DMA engine (master 1). Each master uses the PicoRV32 valid/ready handshake. The block grants round-robin, sequences each access through a fixed three-state FSM, and signals when an access falls outside the populated memory range. It sits between the core's mem_* ports and the testbench/SoC memory array.

## Interface
- ADDR_W, 14, SRAM word-address width (2**ADDR_W words; 14 = 64 KiB)
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- m0_valid  in  1  master 0 request; held until m0_ready
- m0_addr  in  32  master 0 byte address; bits [1:0] ignored
- m0_wdata  in  32  master 0 write data
- m0_wstrb  in  4  master 0 byte enables; 0 means read
- m0_ready  out  1  one-cycle completion pulse to master 0
- m0_rdata  out  32  master 0 read data, valid while m0_ready
- m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: same as master 0, for master 1
- mem_en  out  1  SRAM access enable
- mem_we  out  4  SRAM byte write enables (subset of mem_en cycles)
- mem_addr  out  ADDR_W  SRAM word address
- mem_wdata  out  32  SRAM write data
- mem_rdata  in  32  SRAM read data, valid the cycle after mem_en
- oor_err  out  1  one-cycle pulse: completed access was out of range
- busy  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, ACCESS, DONE. Every access takes exactly IDLE→ACCESS→DONE→IDLE.
- IDLE: if either valid is high, choose grant, latch addr[ADDR_W+1:2], wdata, wstrb and oor flag (addr[31:ADDR_W+2] != 0) into request registers, then go to ACCESS. Otherwise stay in IDLE.
- Arbitration: if only one master is valid, grant it. If both are valid, grant the master that was *not* granted last. last_grant resets to 1, so master 0 wins the first tie.
- ACCESS: mem_en = !oor && !reset. mem_we = latched wstrb when mem_en is high, else 0. mem_addr and mem_wdata come from the request registers. Go to DONE.
- DONE: the granted master's ready = 1. Its rdata = oor ? 0 : mem_rdata, for reads and writes alike. The other master sees ready 0 and rdata 0. oor_err = oor. Update last_grant, then go to IDLE.
- Outside DONE, both rdata outputs are 0. Outside ACCESS, mem_en, mem_we, mem_addr and mem_wdata are 0.
- Out-of-range access: the SRAM is not touched, writes are dropped, reads return 0, and the handshake still completes.
- If a master drops valid after being granted, the access still completes and commits any write. The ready pulse is still issued and is ignored.
- Request inputs are sampled only in IDLE. Changes during ACCESS or DONE have no effect.

## Timing
- Reset values (cycle after reset is sampled high): state IDLE, last_grant 1, all request registers 0. Consequently m0_ready = m1_ready = 0, rdata 0, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0, oor_err 0, busy 0.
- Reset asserted during ACCESS: mem_en and mem_we are forced to 0 in that cycle, so no write commits. Next state is IDLE.
- Reset asserted during DONE: ready is still decoded in that cycle. Next state is IDLE.
- Latency: valid sampled in IDLE at cycle T; mem_en at T+1; ready and rdata at T+2. The earliest next grant is sampled at T+3.
- Throughput: one access per 3 cycles. With both masters continuously valid, grants strictly alternate.
- A valid asserted while the FSM is in DONE is first sampled in the following IDLE cycle.
- busy = 1 in ACCESS and DONE.

## Test plan
- Single read: preload word 0x10 = 0xDEADBEEF; m0 reads 0x40 with wstrb 0. Expect mem_en at T+1 with mem_addr 0x10, and m0_ready=1 with m0_rdata=0xDEADBEEF at T+2, m1_ready=0.
- Byte write: m1 writes 0x44, wdata 0xAABBCCDD, wstrb 0b0100, over 0x11223344. Expect mem_we=0b0100, then an m0 read of 0x44 returns 0x11BB3344.
- Contention: m0 and m1 both valid continuously, eight accesses each. Grant order is m0,m1,m0,m1,…; each master receives a ready every 6 cycles, and there are no double grants.
- Out of range: m0 writes 0x0001_0000 (ADDR_W=14). Expect mem_en to stay 0, oor_err=1 with m0_ready, and memory unchanged. A read at the same address returns 0 with oor_err.
- Reset during a write: assert reset in the ACCESS cycle of an m1 write. Expect mem_we=0 in that cycle, the memory word unchanged, all outputs at reset values, and m0 winning the next tie.
- Dropped valid: m1 deasserts valid in ACCESS of a write. Expect the write committed and m1_ready pulsed at T+2.
